// File: rtl/parking_entry_scheduler.sv
//==============================================================================
// Module      : parking_entry_scheduler
// Description : Shares one entry gate between lanes A/B: PIN check, gate
//               control, passage detection, occupancy and wrong-PIN blocking.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module parking_entry_scheduler #(
    parameter logic [15:0] PIN       = 16'h5990,
    parameter int          MAX_TRIES = 3,
    parameter int          CAPACITY  = 8,
    parameter int          OCC_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vehicle_arrival_a,
    input  logic [15:0]      code_a,
    input  logic             code_ack_a,
    input  logic             vehicle_arrival_b,
    input  logic [15:0]      code_b,
    input  logic             code_ack_b,
    input  logic             vehicle_left,
    input  logic             vehicle_exit,
    output logic             grant_a,
    output logic             grant_b,
    output logic             gate_open,
    output logic             wrong_pin,
    output logic             block_alarm,
    output logic             lot_full,
    output logic [OCC_W-1:0] occupancy
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_CODE = 2'd1,
        S_OPEN      = 2'd2,
        S_BLOCK     = 2'd3
    } state_t;

    localparam logic [OCC_W-1:0] c_capacity  = OCC_W'(CAPACITY);
    localparam logic [OCC_W-1:0] c_occ_one   = OCC_W'(1);
    localparam logic [3:0]       c_max_tries = 4'(MAX_TRIES);

    // Lane encoding for owner / round-robin pointer: 0 = lane A, 1 = lane B.
    state_t           r_state;
    logic             r_owner;
    logic             r_rr_ptr;
    logic [2:0]       r_fail_cnt;
    logic             r_ack_a_q;
    logic             r_ack_b_q;
    logic [OCC_W-1:0] r_occ;
    logic             r_lot_full;
    logic             r_grant_a;
    logic             r_grant_b;
    logic             r_gate_open;
    logic             r_wrong_pin;
    logic             r_block_alarm;

    state_t           w_state_nx;
    logic             w_owner_nx;
    logic             w_rr_nx;
    logic [2:0]       w_fail_nx;
    logic             w_wrong_nx;
    logic [OCC_W-1:0] w_occ_nx;
    logic             w_attempt;
    logic             w_arrival;
    logic [15:0]      w_code;
    logic             w_pin_ok;
    logic             w_full;
    logic [3:0]       w_fail_inc;
    logic             w_entry;

    // Only the granted lane's rising ack edge counts as an attempt.
    assign w_attempt  = r_owner ? (code_ack_b & ~r_ack_b_q) : (code_ack_a & ~r_ack_a_q);
    assign w_arrival  = r_owner ? vehicle_arrival_b : vehicle_arrival_a;
    assign w_code     = r_owner ? code_b : code_a;
    assign w_pin_ok   = (w_code == PIN);
    assign w_fail_inc = {1'b0, r_fail_cnt} + 4'd1;
    assign w_entry    = (r_state == S_OPEN) && vehicle_left;

    // Refuse grants while the registered flag or the live count says full,
    // so the flag's one-cycle lag can never let the lot overfill.
    assign w_full     = r_lot_full || (r_occ >= c_capacity);

    always_comb begin
        w_state_nx = r_state;
        w_owner_nx = r_owner;
        w_rr_nx    = r_rr_ptr;
        w_fail_nx  = r_fail_cnt;
        w_wrong_nx = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_full) begin
                    if (vehicle_arrival_a && vehicle_arrival_b) begin
                        w_owner_nx = r_rr_ptr;
                        w_state_nx = S_WAIT_CODE;
                    end else if (vehicle_arrival_a) begin
                        w_owner_nx = 1'b0;
                        w_state_nx = S_WAIT_CODE;
                    end else if (vehicle_arrival_b) begin
                        w_owner_nx = 1'b1;
                        w_state_nx = S_WAIT_CODE;
                    end
                end
            end
            S_WAIT_CODE: begin
                if (!w_arrival) begin
                    w_state_nx = S_IDLE;
                    w_fail_nx  = 3'd0;
                end else if (w_attempt) begin
                    if (w_pin_ok) begin
                        w_state_nx = S_OPEN;
                        w_fail_nx  = 3'd0;
                    end else begin
                        w_wrong_nx = 1'b1;
                        if (w_fail_inc < c_max_tries) begin
                            w_fail_nx = w_fail_inc[2:0];
                        end else begin
                            w_state_nx = S_BLOCK;
                            w_fail_nx  = 3'd0;
                        end
                    end
                end
            end
            S_OPEN: begin
                if (vehicle_left) begin
                    w_state_nx = S_IDLE;
                    w_rr_nx    = ~r_owner;
                    w_fail_nx  = 3'd0;
                end
            end
            S_BLOCK: begin
                if (w_attempt && w_pin_ok) begin
                    w_state_nx = S_OPEN;
                    w_fail_nx  = 3'd0;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_occ_nx = r_occ;
        if (w_entry && vehicle_exit) begin
            w_occ_nx = r_occ;
        end else if (w_entry) begin
            if (r_occ < c_capacity) begin
                w_occ_nx = r_occ + c_occ_one;
            end
        end else if (vehicle_exit && (r_occ != '0)) begin
            w_occ_nx = r_occ - c_occ_one;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_owner       <= 1'b0;
            r_rr_ptr      <= 1'b0;
            r_fail_cnt    <= 3'd0;
            r_ack_a_q     <= 1'b0;
            r_ack_b_q     <= 1'b0;
            r_occ         <= '0;
            r_lot_full    <= 1'b0;
            r_grant_a     <= 1'b0;
            r_grant_b     <= 1'b0;
            r_gate_open   <= 1'b0;
            r_wrong_pin   <= 1'b0;
            r_block_alarm <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_owner       <= w_owner_nx;
            r_rr_ptr      <= w_rr_nx;
            r_fail_cnt    <= w_fail_nx;
            r_ack_a_q     <= code_ack_a;
            r_ack_b_q     <= code_ack_b;
            r_occ         <= w_occ_nx;
            r_lot_full    <= (r_occ == c_capacity);
            r_grant_a     <= (w_state_nx != S_IDLE) && !w_owner_nx;
            r_grant_b     <= (w_state_nx != S_IDLE) && w_owner_nx;
            r_gate_open   <= (w_state_nx == S_OPEN);
            r_wrong_pin   <= w_wrong_nx;
            r_block_alarm <= (w_state_nx == S_BLOCK);
        end
    end

    assign grant_a     = r_grant_a;
    assign grant_b     = r_grant_b;
    assign gate_open   = r_gate_open;
    assign wrong_pin   = r_wrong_pin;
    assign block_alarm = r_block_alarm;
    assign lot_full    = r_lot_full;
    assign occupancy   = r_occ;

endmodule

`default_nettype wire

// File: tb/tb_parking_entry_scheduler.sv
//==============================================================================
// Module      : tb_parking_entry_scheduler
// Description : Vector table, directed corner sequences and random traffic
//               against a session-level reference model (CAPACITY = 2).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_parking_entry_scheduler;

    localparam int          CAP  = 2;
    localparam int          MAXT = 3;
    localparam logic [15:0] GOOD = 16'h5990;
    localparam logic [15:0] BAD  = 16'h1234;

    logic        clk;
    logic        rst;
    logic        vehicle_arrival_a, code_ack_a, vehicle_arrival_b, code_ack_b;
    logic [15:0] code_a, code_b;
    logic        vehicle_left, vehicle_exit;
    logic        grant_a, grant_b, gate_open, wrong_pin, block_alarm, lot_full;
    logic [3:0]  occupancy;

    int total = 0;
    int bad   = 0;

    parking_entry_scheduler #(
        .PIN(GOOD), .MAX_TRIES(MAXT), .CAPACITY(CAP), .OCC_W(4)
    ) dut (
        .clk(clk), .rst(rst),
        .vehicle_arrival_a(vehicle_arrival_a), .code_a(code_a), .code_ack_a(code_ack_a),
        .vehicle_arrival_b(vehicle_arrival_b), .code_b(code_b), .code_ack_b(code_ack_b),
        .vehicle_left(vehicle_left), .vehicle_exit(vehicle_exit),
        .grant_a(grant_a), .grant_b(grant_b), .gate_open(gate_open),
        .wrong_pin(wrong_pin), .block_alarm(block_alarm), .lot_full(lot_full),
        .occupancy(occupancy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Session-level reference: who holds the gate (-1 = nobody), how many
    // wrong tries, whether the barrier is up / alarmed, and cars inside.
    int m_owner, m_rr, m_tries, m_cars;
    bit m_open, m_blocked, m_wrong, m_lotfull, m_prev_a, m_prev_b;

    task automatic model_reset();
        m_owner = -1; m_rr = 0; m_tries = 0; m_cars = 0;
        m_open = 0; m_blocked = 0; m_wrong = 0; m_lotfull = 0;
        m_prev_a = 0; m_prev_b = 0;
    endtask

    task automatic model_step();
        int  old_cars;
        bit  old_full, atk, ok, arr, entry;
        if (!rst) begin
            model_reset();
            return;
        end
        old_cars = m_cars;
        old_full = m_lotfull;
        atk   = (m_owner == 1) ? (code_ack_b && !m_prev_b) : (code_ack_a && !m_prev_a);
        ok    = ((m_owner == 1) ? code_b : code_a) == GOOD;
        arr   = (m_owner == 1) ? vehicle_arrival_b : vehicle_arrival_a;
        entry = m_open && vehicle_left;
        m_wrong = 0;

        if (entry && vehicle_exit) m_cars = m_cars;
        else if (entry) m_cars = (m_cars < CAP) ? m_cars + 1 : m_cars;
        else if (vehicle_exit && m_cars > 0) m_cars = m_cars - 1;

        if (m_owner < 0) begin
            if (!(old_full || old_cars == CAP)) begin
                if (vehicle_arrival_a && vehicle_arrival_b) m_owner = m_rr;
                else if (vehicle_arrival_a) m_owner = 0;
                else if (vehicle_arrival_b) m_owner = 1;
            end
        end else if (m_open) begin
            if (vehicle_left) begin
                m_rr = 1 - m_owner; m_owner = -1; m_open = 0; m_tries = 0;
            end
        end else if (m_blocked) begin
            if (atk && ok) begin
                m_blocked = 0; m_open = 1; m_tries = 0;
            end
        end else begin
            if (!arr) begin
                m_owner = -1; m_tries = 0;
            end else if (atk) begin
                if (ok) begin
                    m_open = 1; m_tries = 0;
                end else begin
                    m_tries = m_tries + 1;
                    m_wrong = 1;
                    if (m_tries >= MAXT) m_blocked = 1;
                end
            end
        end

        m_lotfull = (old_cars == CAP);
        m_prev_a  = code_ack_a;
        m_prev_b  = code_ack_b;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("model grant_a",     16'(grant_a),     16'(m_owner == 0));
        chk("model grant_b",     16'(grant_b),     16'(m_owner == 1));
        chk("model gate_open",   16'(gate_open),   16'(m_open));
        chk("model wrong_pin",   16'(wrong_pin),   16'(m_wrong));
        chk("model block_alarm", 16'(block_alarm), 16'(m_blocked));
        chk("model lot_full",    16'(lot_full),    16'(m_lotfull));
        chk("model occupancy",   16'(occupancy),   16'(m_cars));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic idle_inputs();
        vehicle_arrival_a = 0; vehicle_arrival_b = 0;
        code_a = BAD; code_b = BAD; code_ack_a = 0; code_ack_b = 0;
        vehicle_left = 0; vehicle_exit = 0;
    endtask

    task automatic do_reset(input int n);
        rst = 0;
        for (int i = 0; i < n; i++) tick();
        rst = 1;
    endtask

    task automatic attempt_a(input logic [15:0] c);
        code_a = c; code_ack_a = 1; tick();
        code_ack_a = 0; tick();
    endtask

    typedef struct {
        bit          arr_a;
        logic [15:0] ca;
        bit          ack_a;
        bit          left;
        bit          ex;
        bit          ga, op, wr, bl, fu;
        logic [3:0]  occ;
    } vec_t;

    function automatic vec_t mk(bit arr_a, logic [15:0] ca, bit ack_a, bit left, bit ex,
                                bit ga, bit op, bit wr, bit bl, bit fu, logic [3:0] occ);
        vec_t v;
        v.arr_a = arr_a; v.ca = ca; v.ack_a = ack_a; v.left = left; v.ex = ex;
        v.ga = ga; v.op = op; v.wr = wr; v.bl = bl; v.fu = fu; v.occ = occ;
        return v;
    endfunction

    vec_t vecs[16];
    int   wait_n;

    initial begin
        // inputs applied this cycle -> outputs expected after the edge
        vecs[0]  = mk(1, GOOD, 0, 0, 0,  1, 0, 0, 0, 0, 0); // grant
        vecs[1]  = mk(1, GOOD, 1, 0, 0,  1, 1, 0, 0, 0, 0); // correct PIN opens
        vecs[2]  = mk(1, GOOD, 0, 1, 0,  0, 0, 0, 0, 0, 1); // passage
        vecs[3]  = mk(0, GOOD, 0, 0, 0,  0, 0, 0, 0, 0, 1);
        vecs[4]  = mk(1, BAD,  0, 0, 0,  1, 0, 0, 0, 0, 1);
        vecs[5]  = mk(1, BAD,  1, 0, 0,  1, 0, 1, 0, 0, 1); // wrong #1
        vecs[6]  = mk(1, BAD,  1, 0, 0,  1, 0, 0, 0, 0, 1); // held ack
        vecs[7]  = mk(1, BAD,  1, 0, 0,  1, 0, 0, 0, 0, 1);
        vecs[8]  = mk(1, BAD,  0, 0, 0,  1, 0, 0, 0, 0, 1);
        vecs[9]  = mk(1, BAD,  1, 0, 0,  1, 0, 1, 0, 0, 1); // wrong #2
        vecs[10] = mk(1, GOOD, 0, 0, 0,  1, 0, 0, 0, 0, 1);
        vecs[11] = mk(1, GOOD, 1, 0, 0,  1, 1, 0, 0, 0, 1); // opens, no alarm
        vecs[12] = mk(1, GOOD, 0, 1, 1,  0, 0, 0, 0, 0, 1); // left+exit: unchanged
        vecs[13] = mk(0, GOOD, 0, 0, 1,  0, 0, 0, 0, 0, 0);
        vecs[14] = mk(0, GOOD, 0, 0, 1,  0, 0, 0, 0, 0, 0); // exit at 0 saturates
        vecs[15] = mk(0, GOOD, 0, 0, 0,  0, 0, 0, 0, 0, 0);

        idle_inputs();
        model_reset();
        do_reset(5);
        chk("reset grant_a",   16'(grant_a),   16'd0);
        chk("reset gate_open", 16'(gate_open), 16'd0);
        chk("reset occupancy", 16'(occupancy), 16'd0);

        for (int i = 0; i < 16; i++) begin
            vehicle_arrival_a = vecs[i].arr_a; code_a = vecs[i].ca; code_ack_a = vecs[i].ack_a;
            vehicle_left = vecs[i].left; vehicle_exit = vecs[i].ex;
            tick();
            chk($sformatf("vec%0d grant_a", i),     16'(grant_a),     16'(vecs[i].ga));
            chk($sformatf("vec%0d grant_b", i),     16'(grant_b),     16'd0);
            chk($sformatf("vec%0d gate_open", i),   16'(gate_open),   16'(vecs[i].op));
            chk($sformatf("vec%0d wrong_pin", i),   16'(wrong_pin),   16'(vecs[i].wr));
            chk($sformatf("vec%0d block_alarm", i), 16'(block_alarm), 16'(vecs[i].bl));
            chk($sformatf("vec%0d lot_full", i),    16'(lot_full),    16'(vecs[i].fu));
            chk($sformatf("vec%0d occupancy", i),   16'(occupancy),   16'(vecs[i].occ));
        end

        // Block and release
        idle_inputs();
        do_reset(2);
        vehicle_arrival_a = 1; tick();
        attempt_a(BAD); attempt_a(BAD);
        code_a = BAD; code_ack_a = 1; tick();
        chk("blk third wrong_pin", 16'(wrong_pin), 16'd1);
        chk("blk alarm set", 16'(block_alarm), 16'd1);
        code_ack_a = 0; vehicle_arrival_b = 1; tick();
        code_ack_a = 1; tick();
        chk("blk fourth no wrong_pin", 16'(wrong_pin), 16'd0);
        chk("blk alarm held", 16'(block_alarm), 16'd1);
        chk("blk lane b waits", 16'(grant_b), 16'd0);
        code_ack_a = 0; vehicle_arrival_a = 0; tick();
        chk("blk arrival drop keeps alarm", 16'(block_alarm), 16'd1);
        code_a = GOOD; code_ack_a = 1; tick();
        chk("blk release alarm", 16'(block_alarm), 16'd0);
        chk("blk release gate", 16'(gate_open), 16'd1);
        code_ack_a = 0; vehicle_left = 1; tick();
        vehicle_left = 0; tick();
        chk("blk then lane b granted", 16'(grant_b), 16'd1);

        // Arbitration from reset with both lanes waiting
        idle_inputs();
        vehicle_arrival_a = 1; vehicle_arrival_b = 1;
        do_reset(2);
        tick();
        chk("arb first A", 16'(grant_a), 16'd1);
        chk("arb first not B", 16'(grant_b), 16'd0);
        code_a = GOOD; code_ack_a = 1; tick();
        code_ack_a = 0; vehicle_left = 1; tick();
        vehicle_left = 0; tick();
        chk("arb then B", 16'(grant_b), 16'd1);
        code_b = GOOD; code_ack_b = 1; tick();
        code_ack_b = 0; vehicle_left = 1; vehicle_exit = 1; tick();
        chk("arb left+exit occupancy", 16'(occupancy), 16'd1);
        vehicle_left = 0; vehicle_exit = 0; tick();
        chk("arb round robin A", 16'(grant_a), 16'd1);

        // Capacity
        idle_inputs();
        do_reset(2);
        for (int k = 0; k < 2; k++) begin
            vehicle_arrival_a = 1; code_a = GOOD; tick();
            code_ack_a = 1; tick();
            code_ack_a = 0; vehicle_left = 1; tick();
            vehicle_left = 0; vehicle_arrival_a = 0; tick();
        end
        vehicle_arrival_a = 1;
        for (int k = 0; k < 3; k++) tick();
        chk("cap lot_full", 16'(lot_full), 16'd1);
        chk("cap occupancy", 16'(occupancy), 16'd2);
        chk("cap no grant", 16'(grant_a), 16'd0);
        vehicle_exit = 1; tick();
        vehicle_exit = 0;
        wait_n = 0;
        while (!grant_a && wait_n < 5) begin
            tick();
            wait_n++;
        end
        chk("cap grant after exit", 16'(grant_a), 16'd1);
        chk("cap occupancy after exit", 16'(occupancy), 16'd1);
        chk("cap lot_full cleared", 16'(lot_full), 16'd0);

        // Mid-operation reset in OPEN, fresh session, reset in BLOCK
        code_a = GOOD; code_ack_a = 1; tick();
        chk("rst pre open", 16'(gate_open), 16'd1);
        rst = 0; tick();
        chk("rst open gate", 16'(gate_open), 16'd0);
        chk("rst open grant", 16'(grant_a), 16'd0);
        chk("rst open occupancy", 16'(occupancy), 16'd0);
        rst = 1; code_ack_a = 0; tick();
        code_ack_a = 1; tick();
        chk("rst fresh open", 16'(gate_open), 16'd1);
        code_ack_a = 0; vehicle_left = 1; tick();
        vehicle_left = 0; tick();
        attempt_a(BAD); attempt_a(BAD); attempt_a(BAD);
        chk("rst pre block", 16'(block_alarm), 16'd1);
        rst = 0; tick();
        chk("rst block alarm", 16'(block_alarm), 16'd0);
        chk("rst block grant", 16'(grant_a), 16'd0);
        chk("rst block occupancy", 16'(occupancy), 16'd0);
        rst = 1;

        // Random traffic against the model
        idle_inputs();
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 7) == 0) vehicle_arrival_a = ~vehicle_arrival_a;
            if ($urandom_range(0, 7) == 0) vehicle_arrival_b = ~vehicle_arrival_b;
            code_a = $urandom_range(0, 1) ? GOOD : 16'($urandom);
            code_b = $urandom_range(0, 1) ? GOOD : 16'($urandom);
            code_ack_a   = ($urandom_range(0, 2) == 0);
            code_ack_b   = ($urandom_range(0, 2) == 0);
            vehicle_left = ($urandom_range(0, 4) == 0);
            vehicle_exit = ($urandom_range(0, 9) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/parking_entry_scheduler.md
Name: parking_entry_scheduler

Overview:
- Shares the lot's single entry gate between two entry lanes (A, B) and sequences PIN check, gate opening and passage detection.
- Tracks lot occupancy, refuses grants when the lot is full, and raises a per-session block alarm after repeated wrong PINs.
- Sits between the lane keypads and sensors and the gate actuator, above the existing single-lane gate logic.

Parameters:
- PIN, 16'h5990, valid access code.
- MAX_TRIES, 3, wrong attempts that trigger the block alarm (range 1..7).
- CAPACITY, 8, maximum vehicles in lot.
- OCC_W, 4, occupancy counter width; must hold CAPACITY.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- vehicle_arrival_a  in  1  lane A presence sensor, level.
- code_a  in  16  lane A entered code.
- code_ack_a  in  1  lane A code-submit, level; rising edge = one attempt.
- vehicle_arrival_b  in  1  lane B presence sensor.
- code_b  in  16  lane B entered code.
- code_ack_b  in  1  lane B code-submit.
- vehicle_left  in  1  gate passage sensor; vehicle cleared the open gate.
- vehicle_exit  in  1  exit-lane sensor; one-cycle pulse per departing vehicle.
- grant_a  out  1  lane A owns the gate session.
- grant_b  out  1  lane B owns the gate session.
- gate_open  out  1  gate actuator.
- wrong_pin  out  1  one-cycle pulse per wrong attempt.
- block_alarm  out  1  too many wrong attempts.
- lot_full  out  1  occupancy == CAPACITY.
- occupancy  out  OCC_W  vehicles currently in lot.

Behaviour:
- Reset (rst=0 at clk edge): state IDLE; all 1-bit outputs 0; occupancy=0; fail_cnt=0; rr_ptr=A; ack edge registers cleared. Reset wins over every other event, mid-session included.
- All outputs are registered. Attempt = code_ack_x is 1 this cycle and was 0 the previous cycle, for the granted lane only. Acks on the non-granted lane are ignored, and their edge history is still tracked.
- IDLE:
  - If lot_full, no grant.
  - If only one lane has arrival high, grant it.
  - If both are high, grant rr_ptr's lane.
  - Next state WAIT_CODE; grant_x=1 from the next cycle.
- WAIT_CODE:
  - Granted arrival drops: go to IDLE, drop grant, fail_cnt=0.
  - Attempt with code==PIN: go to OPEN, fail_cnt=0.
  - Attempt with wrong code and fail_cnt+1 < MAX_TRIES: fail_cnt++, wrong_pin pulses 1 cycle, stay.
  - Attempt with wrong code and fail_cnt+1 == MAX_TRIES: wrong_pin pulses, go to BLOCK.
- OPEN:
  - gate_open=1 and grant held.
  - On vehicle_left=1: occupancy+1, gate_open=0 next cycle, grant dropped, rr_ptr set to the other lane, fail_cnt=0, go to IDLE.
  - Arrival drop is ignored while the gate is open.
- BLOCK:
  - block_alarm=1, gate_open=0, grant held.
  - Further wrong attempts: no wrong_pin pulse, stay.
  - Attempt with code==PIN: block_alarm=0, fail_cnt=0, go to OPEN.
  - Arrival drop does not clear the alarm.
  - The other lane waits until BLOCK is left.
- Occupancy:
  - Same-cycle entry increment (vehicle_left in OPEN) and vehicle_exit decrement leave the count unchanged.
  - vehicle_exit at 0 saturates at 0.
  - Increment never exceeds CAPACITY, because no grant is issued when full.
  - lot_full updates the cycle after the count changes.
- Latency:
  - Grant: 1 cycle after arrival in IDLE.
  - gate_open: 1 cycle after the correct-PIN ack edge.
  - A new grant earliest 1 cycle after returning to IDLE.

Test Plan:
- Basic entry:
  - Stimulus: reset 5 cycles, arrival_a=1, code_a=16'h5990, ack_a rising.
  - Required: grant_a=1, gate_open=1 one cycle after the ack edge.
  - Then vehicle_left=1: occupancy=1, gate_open=0, grant_a=0.
- Two wrong PINs then correct:
  - Stimulus: code_a=16'h1234, ack edges ×2, then 16'h5990.
  - Required: wrong_pin pulses twice, block_alarm stays 0, gate opens.
  - Holding ack high multiple cycles counts as one attempt.
- Block and release:
  - Stimulus: 3 wrong codes on lane A.
  - Required: block_alarm=1; a 4th wrong code gives no change; arrival_b=1 gets no grant.
  - Then correct PIN: block_alarm=0, gate_open=1.
- Arbitration:
  - Stimulus: arrival_a and arrival_b both high from reset.
  - Required: A granted first; after A passes, B granted.
  - Next simultaneous request: A granted again (round-robin).
- Capacity (CAPACITY=2):
  - Stimulus: admit 2 vehicles.
  - Required: lot_full=1; arrival_a gets no grant.
  - Then vehicle_exit pulse: occupancy=1, lot_full=0, grant issued.
  - Simultaneous vehicle_left and vehicle_exit: occupancy unchanged.
  - vehicle_exit at 0: stays 0.
- Mid-operation reset:
  - Stimulus: rst=0 while in OPEN and BLOCK.
  - Required: all outputs 0, occupancy=0 at the next edge; a fresh session works.
